// File: rtl/mem_io_responder_pkg.sv
// Shared encodings for the CPU memory/IO bus and the responder FSM.
// The CPU-side FSM imports the same command and address constants.
package mem_io_responder_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-to-responder command/response bus.
// The master drives commands; the slave returns data and strobes.
interface mem_io_responder_if;

    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;
    logic        bus_err;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  mem_ready,
        input  bus_err
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output mem_ready,
        output bus_err
    );

endinterface

// File: rtl/mem_io_responder_resp_ram.sv
// Single-port 16-bit RAM, synchronous write, registered read.
// The read register only loads on reads, so it holds across writes.
module resp_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory/IO responder: RAM, LED register and switch port behind
// a command bus with a programmable number of wait cycles.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RAM_WORDS   = 256,
    parameter logic [8:0]  LED_ADDR    = LED_ADDR_DEF,
    parameter logic [8:0]  SW_ADDR     = SW_ADDR_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_io_responder_if.slave   bus,
    input  logic [7:0]          sw_in,
    output logic [7:0]          led_out
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t state;
    state_t next;

    logic [1:0]    cmd_q;
    logic [8:0]    addr_q;
    logic [15:0]   wdata_q;
    logic [3:0]    cnt;

    logic          accept;
    logic          go_resp;
    logic [1:0]    acc_cmd;
    logic [8:0]    acc_addr;
    logic [15:0]   acc_data;

    logic          is_read;
    logic          is_write;
    logic          sel_ram;
    logic          sel_led;
    logic          sel_sw;
    logic          err;
    logic [AW-1:0] ram_idx;

    logic          ram_en;
    logic [15:0]   ram_q;
    logic [15:0]   data_q;
    logic          src_ram;
    logic          ready_q;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next    = state;
        accept  = 1'b0;
        go_resp = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.mem_cmd != CMD_NONE) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        next    = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    next    = ST_RESP;
                    go_resp = 1'b1;
                end
            end
            ST_RESP: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    // With zero wait cycles the access happens on the accept edge,
    // so the live bus is used in IDLE and the latched copy otherwise.
    always_comb begin
        acc_cmd  = (state == ST_IDLE) ? bus.mem_cmd    : cmd_q;
        acc_addr = (state == ST_IDLE) ? bus.mem_addr   : addr_q;
        acc_data = (state == ST_IDLE) ? bus.write_data : wdata_q;
        is_read  = (acc_cmd == CMD_READ);
        is_write = (acc_cmd == CMD_WRITE);
        sel_led  = (is_read || is_write) && (acc_addr == LED_ADDR);
        sel_sw   = is_read && (acc_addr == SW_ADDR) && !sel_led;
        sel_ram  = (is_read || is_write) && !acc_addr[8]
                   && !sel_led && !sel_sw;
        err      = !(sel_led || sel_sw || sel_ram);
        ram_idx  = AW'({1'b0, acc_addr[7:0]} % 9'(RAM_WORDS));
    end

    assign ram_en = reset_n && go_resp && sel_ram;

    resp_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (is_write),
        .addr  (ram_idx),
        .wdata (acc_data),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q   <= 2'b00;
            addr_q  <= 9'h000;
            wdata_q <= 16'h0000;
            cnt     <= 4'd0;
            led_out <= 8'h00;
            data_q  <= 16'h0000;
            src_ram <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= go_resp;
            err_q   <= go_resp && err;
            if (accept) begin
                cmd_q   <= bus.mem_cmd;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.write_data;
                cnt     <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp) begin
                unique case (1'b1)
                    err: begin
                        data_q  <= 16'h0000;
                        src_ram <= 1'b0;
                    end
                    sel_ram: begin
                        if (is_read) src_ram <= 1'b1;
                    end
                    sel_led: begin
                        if (is_write) begin
                            led_out <= acc_data[7:0];
                        end else begin
                            data_q  <= {8'h00, led_out};
                            src_ram <= 1'b0;
                        end
                    end
                    sel_sw: begin
                        data_q  <= {8'h00, sw_in};
                        src_ram <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM reads are served straight from the RAM's own read register.
    assign bus.read_data = src_ram ? ram_q : data_q;
    assign bus.mem_ready = ready_q;
    assign bus.bus_err   = err_q;

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, number of wait cycles inserted between command acceptance and response (legal range 0..15).
REQ-002 Parameter: RAM_WORDS, default 256, depth of the internal 16-bit data/instruction RAM.
REQ-003 Parameter: LED_ADDR, default 9'h100, LED output register address.
REQ-004 Parameter: SW_ADDR, default 9'h140, switch input address.
REQ-005 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-007 Port: mem_cmd  input  2  CPU command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved.
REQ-008 Port: mem_addr  input  9  CPU word address.
REQ-009 Port: write_data  input  16  CPU store data.
REQ-010 Port: sw_in  input  8  switch levels, sampled when an SW_ADDR read is performed.
REQ-011 Port: read_data  output  16  response data, registered.
REQ-012 Port: mem_ready  output  1  one-cycle response strobe.
REQ-013 Port: bus_err  output  1  one-cycle error strobe, coincident with mem_ready.
REQ-014 Port: led_out  output  8  LED register contents.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-016 IDLE: mem_cmd of READ, WRITE or reserved SHALL latch cmd/addr/data, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reaches 1.
REQ-018 RESP SHALL assert mem_ready for exactly one cycle and then return to IDLE.
REQ-019 Latency: a command sampled at edge k SHALL give mem_ready high during cycle k+1+WAIT_CYCLES.
REQ-020 A new command SHALL NOT be accepted in RESP; IDLE re-samples mem_cmd on the cycle after RESP, so a held command is serviced again.
REQ-021 Changes on mem_cmd, mem_addr or write_data after acceptance SHALL be ignored; the latched values are used.
REQ-022 Decode: addr[8]=0 selects RAM word addr[7:0]; addresses at or above RAM_WORDS SHALL alias modulo RAM_WORDS.
REQ-023 A RAM read SHALL return the word in read_data at mem_ready; a RAM write SHALL update the word on the edge entering RESP.
REQ-024 A write to LED_ADDR SHALL load led_out with write_data[7:0]; a read of LED_ADDR SHALL return {8'h00, led_out}.
REQ-025 A read of SW_ADDR SHALL return {8'h00, sw_in} as sampled on the edge entering RESP.
REQ-026 The following SHALL pulse bus_err with mem_ready, return read_data 16'h0000 and change no state: a write to SW_ADDR, any other addr[8]=1 address, or a reserved command.
REQ-027 read_data SHALL hold its last value between responses; a WRITE response SHALL leave it unchanged.
REQ-028 mem_cmd NONE in IDLE SHALL keep the block in IDLE with no strobes.

Reset
REQ-029 With reset_n=0 at a rising edge, the block SHALL enter IDLE, and mem_ready, bus_err, read_data and led_out SHALL all be 0.
REQ-030 Reset in WAIT SHALL abort the pending operation: no RAM or LED write and no response strobe.
REQ-031 RAM contents SHALL NOT be cleared by reset; RAM initial contents SHALL come from an init file for simulation.
REQ-032 Reset SHALL override any simultaneous command.

Structure
REQ-033 A shared package SHALL hold the mem_cmd encodings, the FSM state enumeration, and the default LED_ADDR and SW_ADDR constants, shared with the CPU FSM.
REQ-034 The RAM SHALL be one sub-module, resp_ram, single-port, with synchronous write and registered read.

Verification
REQ-035 WAIT_CYCLES=1: WRITE addr 9'h019 data 16'hFFE9, then READ 9'h019 -> mem_ready 2 cycles after each accept; read_data=16'hFFE9 on the read.
REQ-036 WRITE LED_ADDR data 16'h00A5 -> led_out=8'hA5 from the RESP edge; READ LED_ADDR -> 16'h00A5; bus_err stays 0.
REQ-037 sw_in=8'h3C, READ SW_ADDR -> read_data=16'h003C; WRITE SW_ADDR -> bus_err=1 with mem_ready, led_out and RAM unchanged.
REQ-038 reset_n=0 in WAIT of WRITE 9'h005 data 16'h1234 -> no mem_ready; later READ 9'h005 returns the prior value; all outputs 0 during reset.
REQ-039 WAIT_CYCLES=0 and READ held high for 3 requests -> mem_ready on alternate cycles (accept, RESP, accept, ...); mem_addr change after accept has no effect.
REQ-040 mem_cmd=2'b11 at 9'h010 -> bus_err=1, read_data=16'h0000, RAM word 9'h010 unchanged.
